// File: rtl/mac_address_table.sv
// Learning L2 table: lookup result and learn commit 2 cycles after lookup_en, one lookup per cycle, no backpressure.
// GC sweep stalls behind learn commits; define MAC_TABLE_LEARN_BYPASS_EN to forward in-flight learns to lookups.
module mac_address_table #(
  parameter int ROW_BITS  = 8,
  parameter int PORT_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup_en,
  input  logic [11:0]          lookup_src_vlan,
  input  logic [47:0]          lookup_src_mac,
  input  logic [PORT_BITS-1:0] lookup_src_port,
  input  logic [47:0]          lookup_dst_mac,
  output logic                 lookup_done,
  output logic                 lookup_hit,
  output logic [PORT_BITS-1:0] lookup_dst_port,
  input  logic                 gc_en,
  output logic                 gc_done
);

  localparam int ROWS = 1 << ROW_BITS;
  localparam int NCH  = (60 + ROW_BITS - 1) / ROW_BITS;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} gc_state_t;

  // XOR-fold of {vlan, mac}, LSB-first chunks, top chunk zero-padded
  function automatic logic [ROW_BITS-1:0] fold_key(input logic [59:0] key);
    logic [NCH*ROW_BITS-1:0] padded;
    logic [ROW_BITS-1:0]     acc;
    padded       = '0;
    padded[59:0] = key;
    acc          = '0;
    for (int i = 0; i < NCH; i++) acc ^= padded[i*ROW_BITS +: ROW_BITS];
    return acc;
  endfunction

  logic [ROWS-1:0]      valid_q;
  logic [ROWS-1:0]      used_q;
  logic [11:0]          vlan_mem [ROWS];
  logic [47:0]          mac_mem  [ROWS];
  logic [PORT_BITS-1:0] port_mem [ROWS];

  logic                 s1_vld;
  logic [11:0]          s1_vlan;
  logic [47:0]          s1_src_mac;
  logic [PORT_BITS-1:0] s1_src_port;
  logic [47:0]          s1_dst_mac;
  logic [ROW_BITS-1:0]  s1_src_idx;
  logic [ROW_BITS-1:0]  s1_dst_idx;

  logic                 s2_vld;
  logic                 s2_hit;
  logic [PORT_BITS-1:0] s2_port;
  logic                 s2_learn;
  logic [11:0]          s2_vlan;
  logic [47:0]          s2_mac;
  logic [PORT_BITS-1:0] s2_src_port;
  logic [ROW_BITS-1:0]  s2_src_idx;

  logic                 tbl_hit;
  logic [PORT_BITS-1:0] tbl_port;
  logic                 rd_hit;
  logic [PORT_BITS-1:0] rd_port;
  logic                 learn_we;

  gc_state_t            gc_state_q, gc_state_d;
  logic [ROW_BITS-1:0]  gc_ptr_q, gc_ptr_d;
  logic                 gc_touch;

  assign learn_we = s2_learn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld      <= 1'b0;
      s1_vlan     <= '0;
      s1_src_mac  <= '0;
      s1_src_port <= '0;
      s1_dst_mac  <= '0;
      s1_src_idx  <= '0;
      s1_dst_idx  <= '0;
    end else begin
      s1_vld <= lookup_en;
      if (lookup_en) begin
        s1_vlan     <= lookup_src_vlan;
        s1_src_mac  <= lookup_src_mac;
        s1_src_port <= lookup_src_port;
        s1_dst_mac  <= lookup_dst_mac;
        s1_src_idx  <= fold_key({lookup_src_vlan, lookup_src_mac});
        s1_dst_idx  <= fold_key({lookup_src_vlan, lookup_dst_mac});
      end
    end
  end

  always_comb begin
    tbl_hit  = valid_q[s1_dst_idx] && (vlan_mem[s1_dst_idx] == s1_vlan) &&
               (mac_mem[s1_dst_idx] == s1_dst_mac);
    tbl_port = port_mem[s1_dst_idx];
`ifdef MAC_TABLE_LEARN_BYPASS_EN
    // The learn committing this cycle owns the row once it lands, so it replaces the stale read
    if (learn_we && (s2_src_idx == s1_dst_idx)) begin
      tbl_hit  = (s2_vlan == s1_vlan) && (s2_mac == s1_dst_mac);
      tbl_port = s2_src_port;
    end
`endif
    rd_hit  = tbl_hit && !s1_dst_mac[40];
    rd_port = rd_hit ? tbl_port : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld      <= 1'b0;
      s2_hit      <= 1'b0;
      s2_port     <= '0;
      s2_learn    <= 1'b0;
      s2_vlan     <= '0;
      s2_mac      <= '0;
      s2_src_port <= '0;
      s2_src_idx  <= '0;
    end else begin
      s2_vld   <= s1_vld;
      s2_hit   <= s1_vld && rd_hit;
      s2_port  <= s1_vld ? rd_port : '0;
      s2_learn <= s1_vld && !s1_src_mac[40];
      if (s1_vld) begin
        s2_vlan     <= s1_vlan;
        s2_mac      <= s1_src_mac;
        s2_src_port <= s1_src_port;
        s2_src_idx  <= s1_src_idx;
      end
    end
  end

  assign lookup_done     = s2_vld;
  assign lookup_hit      = s2_hit;
  assign lookup_dst_port = s2_port;

  always_ff @(posedge clk) begin
    if (learn_we) begin
      vlan_mem[s2_src_idx] <= s2_vlan;
      mac_mem[s2_src_idx]  <= s2_mac;
      port_mem[s2_src_idx] <= s2_src_port;
    end
  end

  // Learn is applied last so it wins any same-row update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      used_q  <= '0;
    end else begin
      if (gc_touch) begin
        if (used_q[gc_ptr_q]) used_q[gc_ptr_q]  <= 1'b0;
        else                  valid_q[gc_ptr_q] <= 1'b0;
      end
      if (learn_we) begin
        valid_q[s2_src_idx] <= 1'b1;
        used_q[s2_src_idx]  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc_state_q <= IDLE;
      gc_ptr_q   <= '0;
    end else begin
      gc_state_q <= gc_state_d;
      gc_ptr_q   <= gc_ptr_d;
    end
  end

  always_comb begin
    gc_state_d = gc_state_q;
    gc_ptr_d   = gc_ptr_q;
    gc_touch   = 1'b0;
    gc_done    = 1'b0;
    case (gc_state_q)
      IDLE: begin
        if (gc_en) begin
          gc_state_d = SWEEP;
          gc_ptr_d   = '0;
        end
      end
      SWEEP: begin
        if (!learn_we) begin
          gc_touch = 1'b1;
          gc_ptr_d = gc_ptr_q + ROW_BITS'(1);
          if (&gc_ptr_q) gc_state_d = DONE;
        end
      end
      DONE: begin
        gc_done    = 1'b1;
        gc_state_d = IDLE;
      end
      default: gc_state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_address_table.sv
// Directed bench for mac_address_table: stimulus queues expected lookup results, a negedge monitor checks them.
module tb_mac_address_table;

  localparam logic [47:0] MAC_0A = 48'h02_de_ad_be_ef_0a;
  localparam logic [47:0] MAC_0C = 48'h02_de_ad_be_ef_0c;
  localparam logic [47:0] MAC_BC = 48'hff_ff_ff_ff_ff_ff;
  // Multicast source hashing to the same row as {vlan 2, MAC_0A}
  localparam logic [47:0] MAC_MC = 48'h01_00_00_00_00_2b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_en;
  logic [11:0] lookup_src_vlan;
  logic [47:0] lookup_src_mac;
  logic [4:0]  lookup_src_port;
  logic [47:0] lookup_dst_mac;
  logic        lookup_done;
  logic        lookup_hit;
  logic [4:0]  lookup_dst_port;
  logic        gc_en;
  logic        gc_done;

  typedef struct {
    int         id;
    logic       hit;
    logic [4:0] port;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   lk_id   = 0;
  logic seen;

  mac_address_table dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lookup_en       (lookup_en),
    .lookup_src_vlan (lookup_src_vlan),
    .lookup_src_mac  (lookup_src_mac),
    .lookup_src_port (lookup_src_port),
    .lookup_dst_mac  (lookup_dst_mac),
    .lookup_done     (lookup_done),
    .lookup_hit      (lookup_hit),
    .lookup_dst_port (lookup_dst_port),
    .gc_en           (gc_en),
    .gc_done         (gc_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && lookup_done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_done: got lookup_done=1, expected no pending lookup");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("L%0d_hit", e.id), {63'd0, lookup_hit}, {63'd0, e.hit});
        check($sformatf("L%0d_port", e.id), {59'd0, lookup_dst_port}, {59'd0, e.port});
      end
    end
  end

  task automatic drive(input logic [11:0] v, input logic [47:0] s, input logic [4:0] p,
                       input logic [47:0] d, input logic eh, input logic [4:0] ep);
    exp_t e;
    lk_id++;
    lookup_en       = 1'b1;
    lookup_src_vlan = v;
    lookup_src_mac  = s;
    lookup_src_port = p;
    lookup_dst_mac  = d;
    e.id = lk_id; e.hit = eh; e.port = ep;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [11:0] v, input logic [47:0] s, input logic [4:0] p,
                       input logic [47:0] d, input logic eh, input logic [4:0] ep);
    drive(v, s, p, d, eh, ep);
    @(posedge clk); #1;
    lookup_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Starts a sweep and, for the first n_lk cycles, issues hitting lookups that stall it
  task automatic run_gc(input int n_lk, input int exp_cycles, input string name);
    int cnt = 0;
    gc_en = 1'b1;
    do begin
      @(posedge clk); #1;
      cnt++;
      gc_en = 1'b0;
      if (cnt <= n_lk) drive(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b1, 5'h0a);
      else lookup_en = 1'b0;
    end while (!gc_done && cnt < 1000);
    lookup_en = 1'b0;
    check({name, "_latency"}, cnt, exp_cycles);
    @(posedge clk); #1;
    check({name, "_pulse_width"}, {63'd0, gc_done}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; lookup_en = 1'b0; gc_en = 1'b0;
    lookup_src_vlan = '0; lookup_src_mac = '0; lookup_src_port = '0; lookup_dst_mac = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lookup_done", {63'd0, lookup_done}, 64'd0);
    check("reset_lookup_hit", {63'd0, lookup_hit}, 64'd0);
    check("reset_dst_port", {59'd0, lookup_dst_port}, 64'd0);
    check("reset_gc_done", {63'd0, gc_done}, 64'd0);
    rst_n = 1'b1;
    idle(1);

    issue(12'd2, MAC_0C, 5'h0c, MAC_0A, 1'b0, 5'h00);
`ifdef MAC_TABLE_LEARN_BYPASS_EN
    issue(12'd2, MAC_0A, 5'h0a, MAC_0C, 1'b1, 5'h0c);
`else
    issue(12'd2, MAC_0A, 5'h0a, MAC_0C, 1'b0, 5'h00);
`endif
    idle(7);
    issue(12'd2, MAC_0C, 5'h0c, MAC_0A, 1'b1, 5'h0a);
    issue(12'd5, MAC_0C, 5'h0c, MAC_0A, 1'b0, 5'h00);
    issue(12'd2, MAC_0C, 5'h0c, MAC_BC, 1'b0, 5'h00);
    issue(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b1, 5'h0a);
    idle(3);
    issue(12'd2, MAC_0A, 5'h0a, MAC_0C, 1'b1, 5'h03);
    issue(12'd2, MAC_MC, 5'h07, MAC_0C, 1'b1, 5'h03);
    idle(3);
    issue(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b1, 5'h0a);
    idle(4);

    run_gc(0, 257, "gc1");
    issue(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b1, 5'h0a);
    idle(4);
    run_gc(4, 261, "gc2");
    issue(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b0, 5'h00);
    idle(3);
    issue(12'd2, MAC_0A, 5'h0a, MAC_0C, 1'b1, 5'h03);
    idle(4);

    gc_en = 1'b1;
    @(posedge clk); #1;
    gc_en = 1'b0;
    idle(50);
    rst_n = 1'b0;
    #1;
    check("abort_gc_done_in_reset", {63'd0, gc_done}, 64'd0);
    check("abort_lookup_done_in_reset", {63'd0, lookup_done}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (gc_done) seen = 1'b1;
    end
    check("abort_no_gc_done", {63'd0, seen}, 64'd0);
    issue(12'd2, MAC_0A, 5'h0a, MAC_0C, 1'b0, 5'h00);
    idle(3);
    issue(12'd2, MAC_0C, 5'h03, MAC_0A, 1'b1, 5'h0a);
    idle(5);

    check("pending_lookups", exp_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mac_address_table.md
Name: mac_address_table

Overview:
- Learning L2 forwarding table for the switch fabric. Every lookup carries one frame's (VLAN, source MAC, ingress port) and destination MAC.
- On each lookup the block learns the source binding and returns the egress port for the destination, if known.
- A garbage-collection (GC) sweep ages out stations not seen since the previous sweep.
- Sits between the ingress frame parser and the forwarding/flood decision logic.

Parameters:
- ROW_BITS, 8, log2 of table rows; the table is direct-mapped with 2^ROW_BITS rows.
- PORT_BITS, 5, width of port numbers.

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- lookup_en  in  1  single-cycle strobe; the lookup fields below are valid this cycle
- lookup_src_vlan  in  12  VLAN ID of the frame
- lookup_src_mac  in  48  source MAC address
- lookup_src_port  in  PORT_BITS  ingress port
- lookup_dst_mac  in  48  destination MAC address
- lookup_done  out  1  one-cycle pulse; lookup_hit and lookup_dst_port are valid this cycle
- lookup_hit  out  1  destination found in the table
- lookup_dst_port  out  PORT_BITS  learned port of the destination; 0 on a miss
- gc_en  in  1  single-cycle strobe that starts a GC sweep
- gc_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Entry contents: valid, used, vlan[11:0], mac[47:0], port. All valid and used bits live in flops.
- Reset: valid and used bits clear. lookup_done, lookup_hit, lookup_dst_port, gc_done go to 0. The GC FSM goes to IDLE. The pipeline empties.
- Row index: fold the 60-bit key {vlan, mac} into ROW_BITS-wide chunks, starting from the LSB and zero-padding the top chunk, then XOR all chunks together.
- Destination match: row valid AND stored vlan == lookup_src_vlan AND stored mac == lookup_dst_mac.
- Pipeline, lookup issued in cycle N:
  - N: capture inputs and compute both indices.
  - N+1: read the source and destination rows.
  - N+2: lookup_done=1 with the hit result, and the learn write commits.
- Learn write: row[src index] = {valid=1, used=1, vlan, src_mac, src_port}. This overwrites on a hash collision, refreshes an existing entry, and handles station moves (new port replaces old).
- Multicast handling:
  - A source MAC with bit 40 = 1 (multicast/broadcast) is never learned.
  - A destination MAC with bit 40 = 1 always misses.
- No bypass (without the optional feature): the read at N+1 does not see writes committing at N+1 or later. A lookup issued 1 cycle after a learn misses that entry; a lookup issued ≥2 cycles after sees it.
- Throughput: one lookup per cycle, back-to-back.
- GC FSM:
  - States: IDLE, SWEEP, DONE.
  - IDLE→SWEEP on gc_en. The row pointer starts at 0.
  - SWEEP, per row: if used=0, clear valid; otherwise clear used. Then increment the pointer.
  - GC yields to learn writes: if a learn write commits this cycle, the sweep stalls and does not advance.
  - After the last row, go to DONE: gc_done=1 for one cycle, then IDLE.
  - gc_en is ignored outside IDLE.
  - A learn that commits to a row in the same cycle GC would touch it wins, leaving used=1.
- Reset asserted mid-sweep aborts the sweep, with no gc_done.

Optional Feature:
- Macro: MAC_TABLE_LEARN_BYPASS_EN.
- When defined: the destination match at N+1 also compares against learn writes in flight (stages N+1 and N+2). The newest matching in-flight write wins over table contents, so a lookup issued 1 cycle after a learn hits.
- When undefined: no bypass, behaviour exactly as above.
- Both builds keep identical latency and ports.

Test Plan:
- Cold miss: after reset, lookup vlan 2, src 02:de:ad:be:ef:0c, port 0x0c, dst 02:de:ad:be:ef:0a → at N+2 lookup_done=1, hit=0, dst_port=0.
- Back-to-back learn race: the next cycle, lookup vlan 2, src ..:0a, port 0x0a, dst ..:0c → without the macro hit=0; with MAC_TABLE_LEARN_BYPASS_EN, hit=1, port=0x0c.
- Learned hit: 7 cycles later, repeat the first lookup → hit=1, dst_port=0x0a.
- VLAN isolation: same lookup with vlan 5 → hit=0. Also dst ff:ff:ff:ff:ff:ff → hit=0.
- Station move: learn src ..:0c on port 0x03, wait 3 cycles, lookup dst ..:0c in vlan 2 → hit=1, port=0x03.
- Aging: gc_en with no lookups → gc_done after 256 rows (about 257 cycles), and dst ..:0a still hits. Second gc_en, wait for gc_done → dst ..:0a misses. Reset mid-sweep → no gc_done, table empty.
